// File: rtl/ufm_arbiter_pkg.sv
// Purpose : shared arbiter FSM encoding and UFM page-reader constants.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package ufm_arbiter_pkg;

  // The data byte width and default page geometry are shared with ufm_reader.
  localparam int UFM_DATA_W     = 8;
  localparam int UFM_ADDR_W     = 11;
  localparam int UFM_PAGE_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ufm_arbiter_if.sv
// Purpose : bundles the requester-side and ufm_reader-side signals of the arbiter.
// Latency : n/a (wires only).
// Backpr. : ufm_ready gates new transactions; requesters hold req until gnt.
// Ports   : slave = arbiter view, master = requesters + ufm_reader view.
interface ufm_arbiter_if
  import ufm_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = UFM_ADDR_W
) ();

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            gnt;
  logic [UFM_DATA_W-1:0]         data;
  logic [NUM_REQ-1:0]            data_stb;
  logic [NUM_REQ-1:0]            done;
  logic                          err;
  logic                          ufm_start;
  logic [ADDR_WIDTH-1:0]         ufm_addr;
  logic [UFM_DATA_W-1:0]         ufm_data;
  logic                          ufm_data_stb;
  logic                          ufm_ready;

  modport slave (
    input  req, req_addr, ufm_data, ufm_data_stb, ufm_ready,
    output gnt, data, data_stb, done, err, ufm_start, ufm_addr
  );

  modport master (
    output req, req_addr, ufm_data, ufm_data_stb, ufm_ready,
    input  gnt, data, data_stb, done, err, ufm_start, ufm_addr
  );

endinterface

// File: rtl/ufm_arbiter_rr_select.sv
// Purpose : round-robin pick of the first set req bit at or after ptr, cyclically.
// Latency : purely combinational.
// Backpr. : none; valid=0 when no request is set.
// Ports   : req (levels), ptr (start index) -> winner (index), valid.
module rr_select #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int k);
    logic [IDX_W:0] s;
    s = {1'b0, p} + (IDX_W+1)'(k);
    if (s >= (IDX_W+1)'(NUM_REQ)) s = s - (IDX_W+1)'(NUM_REQ);
    return s[IDX_W-1:0];
  endfunction

  // Scan from the farthest offset back to ptr so the last hit written is the
  // closest one at or after ptr.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[wrap_idx(ptr, k)]) begin
        winner = wrap_idx(ptr, k);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ufm_arbiter.sv
// Purpose : round-robin arbiter sharing one ufm_reader among NUM_REQ page-read requesters.
// Latency : gnt/ufm_start 1 cycle after an accepted IDLE cycle; data/data_stb zero-latency pass-through.
// Backpr. : no new transaction while ufm_ready=0; pending req levels wait in IDLE until served.
// Ports   : clk, rst (sync, active-high); bus (slave modport): req/req_addr in, gnt/data/
//           data_stb/done/err out; ufm_start/ufm_addr out, ufm_data/ufm_data_stb/ufm_ready in.
module ufm_arbiter
  import ufm_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = UFM_ADDR_W,
  parameter int PAGE_BYTES = UFM_PAGE_BYTES,
  parameter int TIMEOUT    = 1024
) (
  input  logic          clk,
  input  logic          rst,
  ufm_arbiter_if.slave  bus
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BCNT_W = $clog2(PAGE_BYTES) + 1;
  localparam int TCNT_W = $clog2(TIMEOUT) + 1;

  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(PAGE_BYTES - 1);
  localparam logic [TCNT_W-1:0] TMO_LAST  = TCNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;

  logic [IDX_W-1:0]      rr_winner;
  logic                  rr_valid;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [IDX_W-1:0]      next_ptr;
  logic [NUM_REQ-1:0]    owner_oh;

  logic [NUM_REQ-1:0]    gnt_c, stb_c, done_c;
  logic                  err_c, start_c;
  logic [UFM_DATA_W-1:0] data_c;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (rr_winner),
    .valid  (rr_valid)
  );

  // Address of the current round-robin winner, sampled only on acceptance.
  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_winner == IDX_W'(i)) win_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign owner_oh = NUM_REQ'(1) << owner_q;
  assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    gnt_c   = '0;
    stb_c   = '0;
    done_c  = '0;
    err_c   = 1'b0;
    start_c = 1'b0;
    data_c  = '0;

    case (state_q)
      IDLE: begin
        if (bus.ufm_ready && rr_valid) begin
          owner_d = rr_winner;
          addr_d  = win_addr;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        start_c = 1'b1;
        gnt_c   = owner_oh;
        bcnt_d  = '0;
        tcnt_d  = '0;
        state_d = STREAM;
      end

      STREAM: begin
        data_c = bus.ufm_data;
        tcnt_d = tcnt_q + TCNT_W'(1);
        // Abort wins over a strobe landing in the same cycle.
        if (tcnt_q == TMO_LAST) begin
          done_c  = owner_oh;
          err_c   = 1'b1;
          ptr_d   = next_ptr;
          state_d = IDLE;
        end else if (bus.ufm_data_stb) begin
          stb_c  = owner_oh;
          bcnt_d = bcnt_q + BCNT_W'(1);
          if (bcnt_q == LAST_BYTE) state_d = DRAIN;
        end
      end

      DRAIN: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        // A reader that has gone idle completes normally even on the last timeout cycle.
        if (bus.ufm_ready || (tcnt_q == TMO_LAST)) begin
          done_c  = owner_oh;
          err_c   = !bus.ufm_ready;
          ptr_d   = next_ptr;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Pulses are combinational from state; rst forces them quiet even before the
  // state register has been cleared.
  assign bus.gnt       = rst ? '0   : gnt_c;
  assign bus.data_stb  = rst ? '0   : stb_c;
  assign bus.done      = rst ? '0   : done_c;
  assign bus.err       = rst ? 1'b0 : err_c;
  assign bus.ufm_start = rst ? 1'b0 : start_c;
  assign bus.data      = rst ? '0   : data_c;
  assign bus.ufm_addr  = addr_q;

endmodule

// File: tb/tb_ufm_arbiter.sv
module tb_ufm_arbiter;
  import ufm_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ufm_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(11)) bus ();

  ufm_arbiter #(
    .NUM_REQ    (2),
    .ADDR_WIDTH (11),
    .PAGE_BYTES (16),
    .TIMEOUT    (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ufm_reader model configuration (written by the test, read by the model).
  int m_nstrb   = 16;
  int m_late_at = 0;
  bit m_block   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ufm_reader model: after seeing ufm_start it emits m_nstrb strobes with
  // bytes 0,1,2,... one per cycle starting on the first STREAM cycle, reports
  // ready once they are out, and optionally emits one stray 0xAA strobe at
  // offset m_late_at. When idle, ready follows !m_block.
  initial begin
    bit st;
    bit m_active;
    int m_t;
    m_active = 1'b0;
    m_t = 0;
    bus.ufm_data = '0;
    bus.ufm_data_stb = 1'b0;
    bus.ufm_ready = 1'b1;
    forever begin
      @(negedge clk);
      st = bus.ufm_start;
      @(posedge clk);
      #1;
      bus.ufm_data_stb = 1'b0;
      if (rst) begin
        m_active = 1'b0;
        bus.ufm_ready = 1'b1;
      end else begin
        if (st) begin
          m_active = 1'b1;
          m_t = 0;
        end
        if (m_active) begin
          if (m_t < m_nstrb) begin
            bus.ufm_data_stb = 1'b1;
            bus.ufm_data = 8'(m_t);
          end
          if (m_late_at != 0 && m_t == m_late_at) begin
            bus.ufm_data_stb = 1'b1;
            bus.ufm_data = 8'hAA;
          end
          bus.ufm_ready = (m_t >= m_nstrb);
          if (m_t >= m_nstrb && m_t >= m_late_at) m_active = 1'b0;
          m_t++;
        end else begin
          bus.ufm_ready = !m_block;
        end
      end
    end
  end

  // Waits for a grant, then follows the transaction to its done pulse.
  // exp_wait: negedges from call to the gnt cycle (-1 = unchecked).
  // exp_done: index of the done cycle, counting the first cycle after the
  // ISSUE (gnt) cycle as 0.
  task automatic run_txn(input logic [1:0] eg, input logic [10:0] ea, input int ns,
                         input bit ee, input int exp_done, input int exp_wait,
                         input bit drop, input string tag);
    int w;
    int nb;
    int idx;
    bit got;
    bit regrant;
    w = 0;
    got = 1'b0;
    while (!got && w < 100) begin
      @(negedge clk);
      w++;
      if (bus.gnt != '0) got = 1'b1;
    end
    chk({tag, "/gnt_seen"}, int'(got), 1);
    if (!got) return;
    if (exp_wait >= 0) chk({tag, "/gnt_wait"}, w, exp_wait);
    chk({tag, "/gnt"}, int'(bus.gnt), int'(eg));
    chk({tag, "/ufm_start"}, int'(bus.ufm_start), 1);
    chk({tag, "/ufm_addr"}, int'(bus.ufm_addr), int'(ea));
    if (drop) begin
      @(posedge clk);
      #1;
      bus.req = '0;
      bus.req_addr = ~bus.req_addr;
    end
    nb = 0;
    idx = 0;
    got = 1'b0;
    while (!got && idx < 200) begin
      @(negedge clk);
      if (bus.data_stb != '0) begin
        chk({tag, "/stb_owner"}, int'(bus.data_stb), int'(eg));
        chk({tag, "/byte"}, int'(bus.data), nb);
        nb++;
      end
      if (bus.done != '0) got = 1'b1;
      else idx++;
    end
    chk({tag, "/done_seen"}, int'(got), 1);
    chk({tag, "/done"}, int'(bus.done), int'(eg));
    chk({tag, "/err"}, int'(bus.err), int'(ee));
    chk({tag, "/done_cycle"}, idx, exp_done);
    chk({tag, "/strobes"}, nb, ns);
    chk({tag, "/addr_held"}, int'(bus.ufm_addr), int'(ea));
    if (drop) begin
      regrant = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (bus.gnt != '0) regrant = 1'b1;
      end
      chk({tag, "/no_regrant"}, int'(regrant), 0);
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [10:0] a0;
    logic [10:0] a1;
    logic [1:0]  eg;
    logic [10:0] ea;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int nb;
    int guard;
    int starts;
    bit late_seen;
    bit stb_leak;

    // ptr evolution from 0 (left after the 0,1,0,1 sequence): owner+1 mod 2.
    vecs[0] = '{req: 2'b01, a0: 11'd2042, a1: 11'd0,   eg: 2'b01, ea: 11'd2042}; // ptr 0 -> 1
    vecs[1] = '{req: 2'b11, a0: 11'd5,    a1: 11'd100, eg: 2'b10, ea: 11'd100};  // ptr 1 -> 0
    vecs[2] = '{req: 2'b10, a0: 11'd9,    a1: 11'd7,   eg: 2'b10, ea: 11'd7};    // ptr 0 -> 0
    vecs[3] = '{req: 2'b11, a0: 11'd1234, a1: 11'd3,   eg: 2'b01, ea: 11'd1234}; // ptr 0 -> 1
    vecs[4] = '{req: 2'b01, a0: 11'd2047, a1: 11'd50,  eg: 2'b01, ea: 11'd2047}; // ptr 1 -> 1
    vecs[5] = '{req: 2'b10, a0: 11'd60,   a1: 11'd1,   eg: 2'b10, ea: 11'd1};    // ptr 1 -> 0

    rst = 1'b1;
    bus.req = '0;
    bus.req_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset/gnt", int'(bus.gnt), 0);
    chk("reset/data_stb", int'(bus.data_stb), 0);
    chk("reset/done", int'(bus.done), 0);
    chk("reset/err", int'(bus.err), 0);
    chk("reset/ufm_start", int'(bus.ufm_start), 0);
    chk("reset/ufm_addr", int'(bus.ufm_addr), 0);
    chk("reset/state", int'(dut.state_q), int'(IDLE));
    chk("reset/ptr", int'(dut.ptr_q), 0);
    chk("reset/owner", int'(dut.owner_q), 0);

    // Both requesters from reset, held: order 0,1,0,1 with one IDLE cycle between.
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req = 2'b11;
    bus.req_addr = {11'd20, 11'd10};
    run_txn(2'b01, 11'd10, 16, 1'b0, 16, 2, 1'b0, "rr0");
    run_txn(2'b10, 11'd20, 16, 1'b0, 16, 2, 1'b0, "rr1");
    run_txn(2'b01, 11'd10, 16, 1'b0, 16, 2, 1'b0, "rr2");
    run_txn(2'b10, 11'd20, 16, 1'b0, 16, 2, 1'b1, "rr3");

    // Table: each request is dropped and its address scrambled right after gnt.
    for (int v = 0; v < 6; v++) begin
      @(posedge clk);
      #1;
      bus.req = vecs[v].req;
      bus.req_addr = {vecs[v].a1, vecs[v].a0};
      run_txn(vecs[v].eg, vecs[v].ea, 16, 1'b0, 16, 2, 1'b1, $sformatf("vec%0d", v));
    end

    // ufm_ready held low: no start until it rises, then gnt two cycles later.
    @(negedge clk);
    m_block = 1'b1;
    @(posedge clk);
    #1;
    bus.req = 2'b01;
    bus.req_addr = {11'd0, 11'd300};
    starts = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ufm_start) starts++;
    end
    chk("ready_low/starts", starts, 0);
    m_block = 1'b0;
    run_txn(2'b01, 11'd300, 16, 1'b0, 16, 2, 1'b1, "ready_rise");

    // Timeout: reader stops after 5 bytes; abort lands on cycle 63; stray strobe later.
    m_nstrb = 5;
    m_late_at = 70;
    @(posedge clk);
    #1;
    bus.req = 2'b01;
    bus.req_addr = {11'd0, 11'd77};
    run_txn(2'b01, 11'd77, 5, 1'b1, 63, 2, 1'b1, "tmo");
    chk("tmo/state_idle", int'(dut.state_q), int'(IDLE));
    late_seen = 1'b0;
    stb_leak = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ufm_data_stb) late_seen = 1'b1;
      if (bus.data_stb != '0) stb_leak = 1'b1;
    end
    chk("tmo/late_strobe_seen", int'(late_seen), 1);
    chk("tmo/late_strobe_dropped", int'(stb_leak), 0);
    m_nstrb = 16;
    m_late_at = 0;

    // Reset after 8 strobes: silent abort, then ptr=0 lets bit 1 win req=10.
    @(posedge clk);
    #1;
    bus.req = 2'b01;
    bus.req_addr = {11'd0, 11'd555};
    guard = 0;
    while (bus.gnt == '0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_mid/gnt", int'(bus.gnt), 1);
    nb = 0;
    guard = 0;
    while (nb < 8 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (bus.data_stb != '0) nb++;
      chk("rst_mid/no_done", int'(bus.done), 0);
    end
    chk("rst_mid/strobes", nb, 8);
    rst = 1'b1;
    bus.req = '0;
    @(negedge clk);
    chk("rst_mid/state", int'(dut.state_q), int'(IDLE));
    chk("rst_mid/ptr", int'(dut.ptr_q), 0);
    chk("rst_mid/outs", int'({bus.gnt, bus.data_stb, bus.done, bus.err, bus.ufm_start}), 0);
    chk("rst_mid/data", int'(bus.data), 0);
    chk("rst_mid/ufm_addr", int'(bus.ufm_addr), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.req = 2'b10;
    bus.req_addr = {11'd999, 11'd0};
    run_txn(2'b10, 11'd999, 16, 1'b0, 16, 2, 1'b1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
